// File: rtl/link_pkg.sv
// ============================================================================
//  Module      : link_pkg
//  Description : Shared definitions for the byte-link initiator and responder:
//                state encoding, data width, default frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package link_pkg;

    localparam int LINK_DATA_W    = 8;
    localparam int LINK_NUM_BYTES = 4;
    localparam int LINK_IDX_W     = 4;
    localparam int LINK_DLY_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ACK   = 2'd2
    } link_state_e;

endpackage

`default_nettype wire

// File: rtl/slave_fsm_if.sv
// ============================================================================
//  Module      : slave_fsm_if
//  Description : Request/acknowledge byte handshake between the link
//                initiator (master) and the responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slave_fsm_if;

    logic                             req;
    logic [link_pkg::LINK_DATA_W-1:0] data;
    logic                             ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);

endinterface

`default_nettype wire

// File: rtl/link_delay_ctr.sv
// ============================================================================
//  Module      : link_delay_ctr
//  Description : Counts the wait cycles between byte capture and acknowledge.
//                expired is high on the last waiting cycle, so the owner
//                leaves its wait state after exactly ACK_DELAY cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_delay_ctr
    import link_pkg::*;
#(
    parameter int ACK_DELAY = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start,
    input  wire logic run,
    output logic      expired
);

    localparam logic [LINK_DLY_W-1:0] CNT_LAST = LINK_DLY_W'(ACK_DELAY - 1);

    logic [LINK_DLY_W-1:0] cnt_q;
    logic [LINK_DLY_W-1:0] cnt_d;

    // Restart on capture, advance once per waiting cycle
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/slave_fsm.sv
// ============================================================================
//  Module      : slave_fsm
//  Description : Byte-link responder. Captures one byte per request, answers
//                with a registered acknowledge, and assembles NUM_BYTES bytes
//                into a frame (byte 0 in the low bits).
//                Build option ACK_DELAY_EN: inserts a DELAY state of
//                ACK_DELAY cycles between capture and acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_fsm
    import link_pkg::*;
#(
    parameter int NUM_BYTES = LINK_NUM_BYTES,
    parameter int ACK_DELAY = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    slave_fsm_if.slave                        link,
    output logic [LINK_DATA_W-1:0]            rx_data,
    output logic                              byte_valid,
    output logic [LINK_IDX_W-1:0]             byte_idx,
    output logic [LINK_DATA_W*NUM_BYTES-1:0]  rx_word,
    output logic                              done
);

    localparam logic [LINK_IDX_W-1:0] IDX_LAST = LINK_IDX_W'(NUM_BYTES - 1);

    // Reject configurations outside the supported range at elaboration
    if (NUM_BYTES < 2 || NUM_BYTES > 16 || ACK_DELAY < 1 || ACK_DELAY > 15) begin : g_bad_cfg
        $error("slave_fsm: NUM_BYTES must be 2..16 and ACK_DELAY 1..15");
    end

    link_state_e                                state_q, state_d;
    logic                                       ack_q;
    logic                                       byte_valid_q, byte_valid_d;
    logic                                       done_q, done_d;
    logic [LINK_DATA_W-1:0]                     rx_data_q, rx_data_d;
    logic [LINK_IDX_W-1:0]                      byte_idx_q, byte_idx_d;
    logic [NUM_BYTES-1:0][LINK_DATA_W-1:0]      stage_q, stage_d;
    logic [LINK_DATA_W*NUM_BYTES-1:0]           rx_word_q, rx_word_d;

`ifdef ACK_DELAY_EN
    logic dly_start;
    logic dly_expired;

    link_delay_ctr #(
        .ACK_DELAY (ACK_DELAY)
    ) u_delay_ctr (
        .clk     (clk),
        .rst     (rst),
        .start   (dly_start),
        .run     (state_q == DELAY),
        .expired (dly_expired)
    );
`endif

    // Next-state, capture and frame-assembly decisions
    always_comb begin
        state_d      = state_q;
        rx_data_d    = rx_data_q;
        byte_idx_d   = byte_idx_q;
        stage_d      = stage_q;
        rx_word_d    = rx_word_q;
        byte_valid_d = 1'b0;
        done_d       = 1'b0;
`ifdef ACK_DELAY_EN
        dly_start    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (link.req) begin
                    rx_data_d    = link.data;
                    byte_valid_d = 1'b1;
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (byte_idx_q == LINK_IDX_W'(i)) begin
                            stage_d[i] = link.data;
                        end
                    end
`ifdef ACK_DELAY_EN
                    dly_start = 1'b1;
                    state_d   = DELAY;
`else
                    state_d   = ACK;
`endif
                end
            end
`ifdef ACK_DELAY_EN
            // req is deliberately ignored here: the wait always completes
            DELAY: begin
                if (dly_expired) begin
                    state_d = ACK;
                end
            end
`endif
            ACK: begin
                if (!link.req) begin
                    state_d = IDLE;
                    if (byte_idx_q == IDX_LAST) begin
                        byte_idx_d = '0;
                        rx_word_d  = stage_q;
                        done_d     = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            byte_idx_q   <= '0;
            stage_q      <= '0;
            rx_word_q    <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= (state_d == ACK);
            byte_valid_q <= byte_valid_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            byte_idx_q   <= byte_idx_d;
            stage_q      <= stage_d;
            rx_word_q    <= rx_word_d;
        end
    end

    assign link.ack   = ack_q;
    assign rx_data    = rx_data_q;
    assign byte_valid = byte_valid_q;
    assign byte_idx   = byte_idx_q;
    assign rx_word    = rx_word_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_slave_fsm.sv
// ============================================================================
//  Module      : tb_slave_fsm
//  Description : Directed self-checking bench for slave_fsm (4-byte frames).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slave_fsm;
    import link_pkg::*;

    localparam int NB  = 4;
    localparam int DLY = 3;
`ifdef ACK_DELAY_EN
    localparam int LAT    = DLY;
    localparam int BV_EXP = 19;
`else
    localparam int LAT    = 0;
    localparam int BV_EXP = 18;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 byte_valid;
    logic [3:0]           byte_idx;
    logic [8*NB-1:0]      rx_word;
    logic                 done;

    int checks     = 0;
    int errors     = 0;
    int bv_count   = 0;
    int done_count = 0;

    slave_fsm_if link ();

    slave_fsm #(
        .NUM_BYTES (NB),
        .ACK_DELAY (DLY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .link       (link),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .byte_idx   (byte_idx),
        .rx_word    (rx_word),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (byte_valid === 1'b1) bv_count++;
        if (done === 1'b1)       done_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle request pulse carrying byte b
    task automatic send_byte(input logic [7:0] b, input int idx_before, input logic done_exp);
        link.req  = 1'b1;
        link.data = b;
        tick();
        chk("capture_valid", byte_valid, 1);
        chk("capture_data", rx_data, b);
        chk("capture_idx", byte_idx, idx_before);
        chk("capture_no_done", done, 0);
        link.req  = 1'b0;
        link.data = ~b;
        for (int k = 0; k < LAT; k++) begin
            chk("delay_no_ack", link.ack, 0);
            tick();
        end
        chk("ack_high", link.ack, 1);
        tick();
        chk("ack_low", link.ack, 0);
        chk("idx_next", byte_idx, (idx_before + 1) % NB);
        chk("done", done, done_exp);
    endtask

    initial begin
        rst       = 1'b0;
        link.req  = 1'b1;
        link.data = 8'h77;

        // Reset state, with a request that must not be captured
        repeat (3) tick();
        chk("rst_ack", link.ack, 0);
        chk("rst_bv", byte_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", byte_idx, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_word", rx_word, 32'h0);
        link.req = 1'b0;
        rst      = 1'b1;
        tick();
        chk("post_rst_bv", byte_valid, 0);
        chk("post_rst_idx", byte_idx, 0);

        // Frame A0..A3 with one-cycle pulses
        send_byte(8'hA0, 0, 1'b0);
        send_byte(8'hA1, 1, 1'b0);
        send_byte(8'hA2, 2, 1'b0);
        chk("a_partial_word", rx_word, 32'h0);
        send_byte(8'hA3, 3, 1'b1);
        chk("a_word", rx_word, 32'hA3A2A1A0);
        chk("a_idx_wrap", byte_idx, 0);
        tick();
        chk("a_done_one_cycle", done, 0);

        // req held for five ack cycles; data change and held req ignored
        link.req  = 1'b1;
        link.data = 8'h5C;
        tick();
        chk("hold_valid", byte_valid, 1);
        link.data = 8'h11;
        for (int k = 0; k < LAT; k++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_ack", link.ack, 1);
            if (k > 0) chk("hold_no_recapture", byte_valid, 0);
            if (k < 4) tick();
        end
        link.req = 1'b0;
        tick();
        chk("hold_ack_drop", link.ack, 0);
        chk("hold_rx_data", rx_data, 8'h5C);
        chk("hold_idx", byte_idx, 1);
        chk("hold_word_kept", rx_word, 32'hA3A2A1A0);

        // Second partial byte, then asynchronous reset mid-frame
        send_byte(8'h3C, 1, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_rst_idx", byte_idx, 0);
        chk("async_rst_word", rx_word, 32'h0);
        chk("async_rst_data", rx_data, 8'h00);
        tick();
        rst = 1'b1;

        // Frame B restarts at slot 0
        send_byte(8'hB0, 0, 1'b0);
        send_byte(8'hB1, 1, 1'b0);
        send_byte(8'hB2, 2, 1'b0);
        chk("b_partial_word", rx_word, 32'h0);
        send_byte(8'hB3, 3, 1'b1);
        chk("b_word", rx_word, 32'hB3B2B1B0);

        // Two frames back to back
        send_byte(8'hC0, 0, 1'b0);
        send_byte(8'hC1, 1, 1'b0);
        send_byte(8'hC2, 2, 1'b0);
        send_byte(8'hC3, 3, 1'b1);
        chk("c_word", rx_word, 32'hC3C2C1C0);
        send_byte(8'hD0, 0, 1'b0);
        send_byte(8'hD1, 1, 1'b0);
        chk("d_partial_word", rx_word, 32'hC3C2C1C0);
        send_byte(8'hD2, 2, 1'b0);
        send_byte(8'hD3, 3, 1'b1);
        chk("d_word", rx_word, 32'hD3D2D1D0);

`ifdef ACK_DELAY_EN
        // req toggled during the wait: one capture, same ack timing
        link.req  = 1'b1;
        link.data = 8'hE5;
        tick();
        chk("tog_capture", byte_valid, 1);
        link.req = 1'b0;
        tick();
        chk("tog_no_ack1", link.ack, 0);
        chk("tog_no_bv1", byte_valid, 0);
        link.req = 1'b1;
        tick();
        chk("tog_no_ack2", link.ack, 0);
        chk("tog_no_bv2", byte_valid, 0);
        link.req = 1'b0;
        tick();
        chk("tog_ack", link.ack, 1);
        tick();
        chk("tog_ack_drop", link.ack, 0);
        chk("tog_rx_data", rx_data, 8'hE5);
        chk("tog_idx", byte_idx, 1);
`endif

        tick();
        chk("total_byte_valid", bv_count, BV_EXP);
        chk("total_done", done_count, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
